// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the data-memory responder
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam int WORD_BYTES      = 4;
    localparam int DEFAULT_LATENCY = 4;

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - MEM-stage load/store request/acknowledge bundle
interface dmem_responder_if;

    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        ack_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        busy_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i,
        input  ack_o, rdata_o, err_o, busy_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        output ack_o, rdata_o, err_o, busy_o
    );

endinterface

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word storage with synchronous write and registered read port
module dmem_array #(
    parameter  int DEPTH_WORDS = 256,
    localparam int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [31:0]   wr_data_i,
    input  logic          rd_en_i,
    input  logic          rd_clr_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [31:0]   rd_data_o
);

    // Contents survive reset, so the array itself has no reset term.
    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rd_data_q;
    logic [31:0] rd_data_d;

    // Write port: one word per cycle when enabled.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    // Read register holds its value unless a read (or a fault clear) is requested.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en_i) begin
            rd_data_d = rd_clr_i ? 32'h0 : mem[rd_addr_i];
        end
    end

    // Read data register, cleared by reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_data_q <= 32'h0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle data-memory target with programmable latency
module dmem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = DEFAULT_LATENCY
) (
    input  logic             clk_i,
    input  logic             rst_i,
    dmem_responder_if.slave  bus
);

    localparam int CW = $clog2(LATENCY) + 1;
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int OB = $clog2(WORD_BYTES);

    dmem_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          we_q, we_d;
    logic          err_q, err_d;

    logic          fault;
    logic          do_access;
    logic [AW-1:0] word_idx;

    // Fault and index are judged on the values captured at accept time.
    assign fault     = (addr_q[OB-1:0] != '0) || ((addr_q >> OB) >= 32'(DEPTH_WORDS));
    assign word_idx  = addr_q[OB +: AW];
    assign do_access = (state_q == WAIT) && (cnt_q == '0);

    // Next-state, counter and request-capture logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_i) begin
                    addr_d  = bus.addr_i;
                    wdata_d = bus.wdata_i;
                    we_d    = bus.we_i;
                    err_d   = 1'b0;
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    err_d   = fault;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers; a reset mid-access discards the captured request.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end

    // Stores write only when clean; loads and any fault update the read register.
    dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (do_access && we_q && !fault),
        .wr_addr_i (word_idx),
        .wr_data_i (wdata_q),
        .rd_en_i   (do_access && (!we_q || fault)),
        .rd_clr_i  (fault),
        .rd_addr_i (word_idx),
        .rd_data_o (bus.rdata_o)
    );

    assign bus.ack_o  = (state_q == RESP);
    assign bus.err_o  = err_q;
    assign bus.busy_o = bus.req_i & ~bus.ack_o;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder: the target side of the CPU MEM-stage load/store interface. It replaces the single-cycle data memory with a req/ack handshake and a programmable access latency. `busy_o` tells the pipeline to hold all stages while an access is pending. Word storage is internal.

## Interface
Parameters:
- `DEPTH_WORDS`, 256: number of 32-bit words stored.
- `LATENCY`, 4: cycles spent in WAIT per access. Must be ≥1.

Ports:
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-low.
- `req_i` in 1: access request. Held with the address and data stable until `ack_o`.
- `we_i` in 1: 1 = store (sw), 0 = load (lw).
- `addr_i` in 32: byte address.
- `wdata_i` in 32: store data.
- `ack_o` out 1: one-cycle completion pulse.
- `rdata_o` out 32: load data, valid while `ack_o`=1. Holds its value afterwards.
- `err_o` out 1: access faulted. Valid with `ack_o`.
- `busy_o` out 1: pipeline stall request, combinational `req_i & ~ack_o`.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If `req_i`=1, latch `addr_i`, `we_i` and `wdata_i`.
  - Load `cnt` ← LATENCY-1 and go to WAIT.
- WAIT:
  - If `cnt`≠0, decrement `cnt` and stay in WAIT.
  - If `cnt`=0, perform the access and go to RESP.
- RESP: `ack_o`=1 and `err_o` is valid. Next state is IDLE unconditionally.
- Access is performed on the edge that enters RESP, using the latched values:
  - Store: `mem[addr[31:2]]` ← wdata. `rdata_o` is unchanged.
  - Load: `rdata_o` ← `mem[addr[31:2]]`.
- Fault condition: `addr[1:0]`≠0, or `addr[31:2]` ≥ DEPTH_WORDS.
  - On a fault: no write, `rdata_o` ← 0, `err_o` ← 1.
  - `err_o` is cleared on the next accept.
- Input changes during WAIT are ignored, because all values were latched at accept.
  - Dropping `req_i` mid-access does not abort it. The access completes and `ack_o` still pulses.
- Back-to-back access:
  - IDLE samples `req_i` in the cycle after RESP, so a new request is accepted then.
  - The minimum spacing between two acks is LATENCY+2 cycles.
- `cnt` width is `$clog2(LATENCY)+1`. It never underflows.
- Memory contents are not affected by reset. The bench preloads them.

## Timing
- With `req_i` first high in cycle 0, `ack_o`=1 in cycle LATENCY+1. For LATENCY=4 that is cycle 5.
- `busy_o` is 1 in cycles 0…LATENCY and 0 in the ack cycle. The pipeline advances on the edge that ends the ack cycle.
- Reset (`rst_i`=0), applied asynchronously at any time including mid-WAIT:
  - State → IDLE, `cnt` → 0.
  - `ack_o`=0, `err_o`=0, `rdata_o`=0.
  - A pending store is dropped with memory unchanged. A store already performed stays.
- After `rst_i` deasserts, the first accept happens on the first rising edge where `req_i`=1.
- Edge case `req_i`=1 with `rst_i`=0: no accept. `busy_o` = `req_i` = 1.

## Structure
- Shared package `mem_pkg` holds:
  - the state enum `dmem_state_t` (IDLE, WAIT, RESP);
  - `WORD_BYTES`=4;
  - the default-latency constant.
- Sub-module `dmem_array`: synchronous write, registered read port, depth parameter. The fault check, FSM and counter stay in `dmem_responder`.

## Test plan
- Reset, then load from 0x0000_0010 with `mem[4]`=0xDEAD_BEEF and LATENCY=4 → `ack_o` in cycle 5, `rdata_o`=0xDEAD_BEEF, `err_o`=0, `busy_o` high for cycles 0–4.
- Store of 0x1234_5678 to 0x20, then load from 0x20 → second ack returns 0x1234_5678, and the acks are exactly 6 cycles apart (req held continuously).
- Store to 0x22 (misaligned), then load from 0x400 (index 256 ≥ DEPTH_WORDS) → both ack with `err_o`=1 and `rdata_o`=0. `mem[8]` is unchanged.
- Change `addr_i` and `wdata_i`, and drop `req_i`, during WAIT → the originally latched access completes, with ack in cycle 5 and the write going to the original address.
- Assert `rst_i`=0 in cycle 2 of a store to 0x30 → outputs immediately 0, state IDLE, no ack, `mem[12]` unchanged. The next request completes normally.
- LATENCY=1 instance: load → `ack_o` in cycle 2. With `req_i` held continuously, acks occur every 3 cycles.
